// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Moore control FSM for a multi-cycle MIPS datapath. Each instruction runs
// over several clock cycles, and one memory port serves both instruction
// fetch and data access. Supported instructions: ADD/SUB/AND/OR/NOR (R-type),
// ADDI, LW, SW, BEQ and J. Unsupported encodings raise a one-cycle illegal
// pulse and are dropped. Memory stalls are bounded by a wait counter that
// moves the FSM to a sticky FAULT state once TIMEOUT is reached.
//
// Parameters
//   TIMEOUT  maximum consecutive mem_ready-low cycles in a memory state
//            before a fault is raised (0 disables the timeout)
//   CNT_W    width of the retired-instruction counter
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   i_instr          instruction register contents (valid from DECODE on)
//   i_zero           ALU zero flag (consumed by the datapath via PCWriteCond)
//   i_mem_ready      memory finished the current read/write this cycle
//   o_pc_write       PCWrite
//   o_pc_write_cond  PCWriteCond
//   o_iord           IorD (0 = PC address, 1 = ALUOut address)
//   o_ir_write       IRWrite
//   o_mem_read       MemRead
//   o_mem_write      MemWrite
//   o_reg_dst        RegDst (1 = rd, 0 = rt)
//   o_alu_src_a      ALUSrcA (0 = PC, 1 = rs)
//   o_mem_to_reg     MemToReg
//   o_reg_write      RegWrite
//   o_alu_src_b      ALUSrcB: 00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   o_pc_source      PCSource: 00 ALU result, 01 ALUOut, 10 jump target
//   o_alu_op         ALU function in funct encoding
//   o_state          current state code (debug)
//   o_instr_done     pulse in the final cycle of each retired instruction
//   o_illegal        pulse in DECODE for an unsupported opcode/funct
//   o_fault          sticky memory-timeout fault (high while in FAULT)
//   o_retired        retired-instruction count, wraps modulo 2^CNT_W
//
// Memory handshake: a request (o_mem_read or o_mem_write) is held steady for
// as long as the FSM sits in FETCH, MEM_READ or MEM_WRITE. The transfer
// completes in the cycle where i_mem_ready is high; the FSM leaves the
// memory state on the following rising edge. i_mem_ready is ignored in every
// other state.
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      i_instr,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_pc_write,
  output logic             o_pc_write_cond,
  output logic             o_iord,
  output logic             o_ir_write,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_reg_dst,
  output logic             o_alu_src_a,
  output logic             o_mem_to_reg,
  output logic             o_reg_write,
  output logic [1:0]       o_alu_src_b,
  output logic [1:0]       o_pc_source,
  output logic [5:0]       o_alu_op,
  output logic [3:0]       o_state,
  output logic             o_instr_done,
  output logic             o_illegal,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_retired
);

  // ---------------------------------------------------------------------------
  // State encoding (codes are visible on o_state for debug)
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_R_WB      = 4'd8,
    S_EXEC_I    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_FAULT     = 4'd15
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU functions (funct encoding)
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;

  // The wait counter only ever needs to hold values up to TIMEOUT-1: the
  // cycle that would bring it to TIMEOUT is the one that faults instead.
  localparam int            CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit            TO_EN     = (TIMEOUT > 0);

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_wait_cnt;
  logic [CNT_W-1:0]   r_retired;

  logic [5:0]         w_opcode;
  logic [5:0]         w_funct;
  logic               w_funct_ok;
  logic               w_is_wait;
  logic               w_timeout;
  logic               w_unused;

  assign w_opcode = i_instr[31:26];
  assign w_funct  = i_instr[5:0];

  // Register fields and the zero flag are consumed by the datapath only.
  assign w_unused = ^{i_zero, i_instr[25:6]};

  always_comb begin
    w_funct_ok = 1'b0;
    case (w_funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR: w_funct_ok = 1'b1;
      default:                               w_funct_ok = 1'b0;
    endcase
  end

  // States that own the memory port and therefore wait on i_mem_ready.
  assign w_is_wait = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                     (r_state == S_MEM_WRITE);

  // A ready in the last allowed cycle still completes the transfer, so the
  // timeout only fires when ready is low.
  assign w_timeout = TO_EN && w_is_wait && !i_mem_ready &&
                     (r_wait_cnt == WAIT_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = S_FETCH;

      S_FETCH: begin
        if (i_mem_ready)    w_next = S_DECODE;
        else if (w_timeout) w_next = S_FAULT;
        else                w_next = S_FETCH;
      end

      S_DECODE: begin
        case (w_opcode)
          OP_RTYPE:     w_next = w_funct_ok ? S_EXEC_R : S_FETCH;
          OP_ADDI:      w_next = S_EXEC_I;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end

      S_MEM_ADDR: w_next = (w_opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;

      S_MEM_READ: begin
        if (i_mem_ready)    w_next = S_MEM_WB;
        else if (w_timeout) w_next = S_FAULT;
        else                w_next = S_MEM_READ;
      end

      S_MEM_WB: w_next = S_FETCH;

      S_MEM_WRITE: begin
        if (i_mem_ready)    w_next = S_FETCH;
        else if (w_timeout) w_next = S_FAULT;
        else                w_next = S_MEM_WRITE;
      end

      S_EXEC_R: w_next = S_R_WB;
      S_R_WB:   w_next = S_FETCH;
      S_EXEC_I: w_next = S_I_WB;
      S_I_WB:   w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (Moore, plus funct in EXEC_R and mem_ready in FETCH /
  // MEM_WRITE). Everything defaults to 0, so IDLE and reset drive all zeros.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_iord          = 1'b0;
    o_ir_write      = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_reg_dst       = 1'b0;
    o_alu_src_a     = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_reg_write     = 1'b0;
    o_alu_src_b     = 2'b00;
    o_pc_source     = 2'b00;
    o_alu_op        = 6'b000000;
    o_instr_done    = 1'b0;
    o_illegal       = 1'b0;
    o_fault         = 1'b0;

    case (r_state)
      S_FETCH: begin
        // PC+4 is computed every fetch cycle but only committed, together
        // with the IR load, in the cycle the memory returns the word.
        o_mem_read  = 1'b1;
        o_alu_src_b = 2'b01;
        o_alu_op    = FN_ADD;
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
      end

      S_DECODE: begin
        // Branch target PC + (imm<<2) is precomputed into ALUOut here.
        o_alu_src_b = 2'b11;
        o_alu_op    = FN_ADD;
        case (w_opcode)
          OP_RTYPE:                          o_illegal = !w_funct_ok;
          OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: o_illegal = 1'b0;
          default:                           o_illegal = 1'b1;
        endcase
      end

      S_MEM_ADDR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        o_alu_op    = FN_ADD;
      end

      S_MEM_READ: begin
        o_mem_read = 1'b1;
        o_iord     = 1'b1;
      end

      S_MEM_WB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
        o_instr_done = 1'b1;
      end

      S_MEM_WRITE: begin
        // A store has no writeback, so it retires in the cycle memory accepts.
        o_mem_write  = 1'b1;
        o_iord       = 1'b1;
        o_instr_done = i_mem_ready;
      end

      S_EXEC_R: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = w_funct;
      end

      S_R_WB: begin
        o_reg_write  = 1'b1;
        o_reg_dst    = 1'b1;
        o_instr_done = 1'b1;
      end

      S_EXEC_I: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        o_alu_op    = FN_ADD;
      end

      S_I_WB: begin
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
      end

      S_BRANCH: begin
        o_alu_src_a     = 1'b1;
        o_alu_op        = FN_SUB;
        o_pc_write_cond = 1'b1;
        o_pc_source     = 2'b01;
        o_instr_done    = 1'b1;
      end

      S_JUMP: begin
        o_pc_write   = 1'b1;
        o_pc_source  = 2'b10;
        o_instr_done = 1'b1;
      end

      S_FAULT: o_fault = 1'b1;

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Wait counter: counts consecutive stalled cycles within one memory state.
  // It clears whenever the FSM changes state (entry into a memory state, or a
  // completed transfer) and whenever ready is seen.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_is_wait && !i_mem_ready && (w_next == r_state)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Retired-instruction counter (wraps naturally)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (o_instr_done) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign o_state   = r_state;
  assign o_retired = r_retired;

endmodule
